fifo_stream_serializer: RTL and testbench

Read-side companion to the team's synchronous FIFO. It pops full-width words from the FIFO, with the FIFO's one-cycle read latency, and emits each word as narrower slices on a valid/ready output stream. It sits between a FIFO's pop port and a narrow consumer, such as a byte-wide UART/SPI transmitter or a bus beat packer.

---
 rtl/fifo_stream_serializer_pkg.sv | 22 ++
 rtl/counter.sv | 20 ++
 rtl/fifo_stream_serializer.sv | 106 ++++++++++
 tb/tb_fifo_stream_serializer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_serializer_pkg.sv
// Shared definitions for the FIFO read-side serializer and the FIFO bench:
// state encoding and slice-count / index-width derivation.
package fifo_stream_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2
  } serState_e;

  localparam int defaultBitWidth = 32;
  localparam int defaultOutWidth = 8;

  function automatic int sliceCount(input int bitWidth, input int outWidth);
    return bitWidth / outWidth;
  endfunction

  function automatic int indexWidthOf(input int nrOfSlices);
    return (nrOfSlices > 1) ? $clog2(nrOfSlices) : 1;
  endfunction

endpackage

// File: rtl/counter.sv
// Generic up/down counter with synchronous active-high reset and enable.
module counter #(
  parameter int WIDTH     = 4,
  parameter bit direction = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (enable) begin
      count <= direction ? count + WIDTH'(1) : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/fifo_stream_serializer.sv
// Pops full-width words from a synchronous FIFO (one-cycle read latency) and
// emits each one as outWidth-bit slices on a valid/ready stream.
module fifo_stream_serializer
  import fifo_stream_serializer_pkg::*;
#(
  parameter int bitWidth = defaultBitWidth,
  parameter int outWidth = defaultOutWidth,
  parameter bit lsbFirst = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fifoEmpty,
  output logic                fifoPop,
  input  logic [bitWidth-1:0] fifoPopData,
  output logic                outValid,
  input  logic                outReady,
  output logic [outWidth-1:0] outData,
  output logic                busy
);

  localparam int nrOfSlices = sliceCount(bitWidth, outWidth);
  localparam int indexWidth = indexWidthOf(nrOfSlices);
  localparam logic [indexWidth-1:0] lastIndex = indexWidth'(nrOfSlices - 1);

  serState_e             state;
  serState_e             stateNext;
  logic [bitWidth-1:0]   wordReg;
  logic [indexWidth-1:0] sliceIndex;
  logic [indexWidth-1:0] nextIndex;
  logic                  transfer;
  logic                  lastSlice;
  logic                  popRequest;

  // Slice position in the word depends on the transmit order.
  function automatic logic [outWidth-1:0] sliceOf(input logic [bitWidth-1:0]   word,
                                                  input logic [indexWidth-1:0] idx);
    logic [indexWidth-1:0] pos;
    pos = lsbFirst ? idx : lastIndex - idx;
    return word[int'(pos)*outWidth +: outWidth];
  endfunction

  assign transfer  = outValid && outReady;
  assign lastSlice = (sliceIndex == lastIndex);
  assign nextIndex = sliceIndex + indexWidth'(1);
  assign busy      = (state != IDLE);
  assign fifoPop   = popRequest && !reset;

  counter #(
    .WIDTH    (indexWidth),
    .direction(1'b1)
  ) sliceCounter (
    .clock (clock),
    .reset (reset),
    .enable(transfer),
    .count (sliceIndex)
  );

  always_comb begin
    stateNext  = state;
    popRequest = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          popRequest = 1'b1;
          stateNext  = WAIT;
        end
      end
      WAIT: stateNext = SHIFT;
      SHIFT: begin
        if (transfer && lastSlice) begin
          if (!fifoEmpty) begin
            popRequest = 1'b1;
            stateNext  = WAIT;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // outData is preloaded with the next slice so it never depends on outReady combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      wordReg  <= '0;
      outValid <= 1'b0;
      outData  <= '0;
    end else begin
      state <= stateNext;
      if (state == WAIT) begin
        wordReg  <= fifoPopData;
        outData  <= sliceOf(fifoPopData, '0);
        outValid <= 1'b1;
      end else if (transfer) begin
        if (lastSlice) begin
          outValid <= 1'b0;
        end else begin
          outData <= sliceOf(wordReg, nextIndex);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_serializer.sv
// Directed bench: an LSB-first and an MSB-first serializer share one modelled FIFO.
module tb_fifo_stream_serializer;

  logic        clock;
  logic        reset;
  logic        fifoEmpty;
  logic [31:0] fifoPopData;
  logic        outReady;

  logic        fifoPop0, outValid0, busy0;
  logic [7:0]  outData0;
  logic        fifoPop1, outValid1, busy1;
  logic [7:0]  outData1;

  logic [31:0] fifoQ[$];
  logic        popSeen;
  int          checkCount;
  int          passCount;

  fifo_stream_serializer #(.bitWidth(32), .outWidth(8), .lsbFirst(1'b1)) dutLsb (
    .clock      (clock),
    .reset      (reset),
    .fifoEmpty  (fifoEmpty),
    .fifoPop    (fifoPop0),
    .fifoPopData(fifoPopData),
    .outValid   (outValid0),
    .outReady   (outReady),
    .outData    (outData0),
    .busy       (busy0)
  );

  fifo_stream_serializer #(.bitWidth(32), .outWidth(8), .lsbFirst(1'b0)) dutMsb (
    .clock      (clock),
    .reset      (reset),
    .fifoEmpty  (fifoEmpty),
    .fifoPop    (fifoPop1),
    .fifoPopData(fifoPopData),
    .outValid   (outValid1),
    .outReady   (outReady),
    .outData    (outData1),
    .busy       (busy1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    assert (!(fifoPop0 && fifoEmpty) && !(fifoPop1 && fifoEmpty))
      else $error("[TB] FAIL popWhileEmpty: fifoPop=%b/%b while fifoEmpty=1", fifoPop0, fifoPop1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [31:0] word);
    fifoQ.push_back(word);
    fifoEmpty = 1'b0;
    #1;
  endtask

  // One clock: the FIFO model delivers the popped word one cycle after the pop cycle.
  task automatic tick();
    #1 popSeen = fifoPop0;
    @(posedge clock);
    #1;
    if (popSeen && fifoQ.size() > 0) begin
      fifoPopData = fifoQ.pop_front();
      fifoEmpty   = (fifoQ.size() == 0);
    end
    @(negedge clock);
  endtask

  task automatic checkSlice(input string tag, input logic [7:0] lsbByte, input logic [7:0] msbByte);
    checkOutput({tag, ".valid"}, 32'({outValid1, outValid0}), 32'h3);
    checkOutput({tag, ".lsbFirst"}, 32'(outData0), 32'(lsbByte));
    checkOutput({tag, ".msbFirst"}, 32'(outData1), 32'(msbByte));
  endtask

  task automatic checkPop(input string tag, input logic expected);
    checkOutput(tag, 32'({fifoPop1, fifoPop0}), expected ? 32'h3 : 32'h0);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput(tag, 32'({fifoPop1, outValid1, busy1, fifoPop0, outValid0, busy0}), 32'h0);
  endtask

  initial begin
    checkCount  = 0;
    passCount   = 0;
    popSeen     = 1'b0;
    reset       = 1'b1;
    fifoEmpty   = 1'b1;
    outReady    = 1'b0;
    fifoPopData = 32'h0;
    repeat (2) @(negedge clock);
    checkIdle("reset.idle");
    checkOutput("reset.data", 32'({outData1, outData0}), 32'h0);
    reset    = 1'b0;
    outReady = 1'b1;

    $display("[TB] single word 0xA1B2C3D4");
    applyStimulus(32'hA1B2C3D4);
    checkPop("single.pop", 1'b1);
    tick();
    checkOutput("single.wait", 32'({busy1, busy0, outValid1, outValid0, fifoPop1, fifoPop0}), 32'h30);
    tick(); checkSlice("single.s0", 8'hD4, 8'hA1);
    tick(); checkSlice("single.s1", 8'hC3, 8'hB2);
    tick(); checkSlice("single.s2", 8'hB2, 8'hC3);
    tick(); checkSlice("single.s3", 8'hA1, 8'hD4);
    checkPop("single.lastNoPop", 1'b0);
    tick(); checkIdle("single.done");

    $display("[TB] backpressure");
    applyStimulus(32'hA1B2C3D4);
    tick();
    tick(); checkSlice("stall.s0", 8'hD4, 8'hA1);
    tick(); checkSlice("stall.s1", 8'hC3, 8'hB2);
    outReady = 1'b0;
    applyStimulus(32'hCAFEF00D);
    checkPop("stall.noPopNow", 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkSlice("stall.hold", 8'hC3, 8'hB2);
      checkPop("stall.noPop", 1'b0);
    end
    outReady = 1'b1;
    tick(); checkSlice("stall.s2", 8'hB2, 8'hC3);
    tick(); checkSlice("stall.s3", 8'hA1, 8'hD4);
    checkPop("stall.nextPop", 1'b1);
    tick(); checkOutput("stall.bubble", 32'({outValid1, outValid0}), 32'h0);
    tick(); checkSlice("stall.n0", 8'h0D, 8'hCA);
    tick(); checkSlice("stall.n1", 8'hF0, 8'hFE);
    tick(); checkSlice("stall.n2", 8'hFE, 8'hF0);
    tick(); checkSlice("stall.n3", 8'hCA, 8'h0D);
    tick(); checkIdle("stall.done");

    $display("[TB] back-to-back");
    applyStimulus(32'h11223344);
    applyStimulus(32'h55667788);
    checkPop("b2b.pop0", 1'b1);
    tick(); checkPop("b2b.waitNoPop", 1'b0);
    tick(); checkSlice("b2b.a0", 8'h44, 8'h11);
    tick(); checkSlice("b2b.a1", 8'h33, 8'h22);
    tick(); checkSlice("b2b.a2", 8'h22, 8'h33);
    tick(); checkSlice("b2b.a3", 8'h11, 8'h44);
    checkPop("b2b.pop1", 1'b1);
    tick();
    checkOutput("b2b.bubble", 32'({outValid1, outValid0, busy1, busy0}), 32'h3);
    tick(); checkSlice("b2b.b0", 8'h88, 8'h55);
    tick(); checkSlice("b2b.b1", 8'h77, 8'h66);
    tick(); checkSlice("b2b.b2", 8'h66, 8'h77);
    tick(); checkSlice("b2b.b3", 8'h55, 8'h88);
    checkPop("b2b.lastNoPop", 1'b0);
    tick(); checkIdle("b2b.done");

    $display("[TB] empty FIFO");
    for (int i = 0; i < 20; i++) begin
      tick();
      checkIdle("empty.idle");
    end

    $display("[TB] reset mid-word");
    applyStimulus(32'hA1B2C3D4);
    tick();
    tick(); checkSlice("rst.s0", 8'hD4, 8'hA1);
    tick(); checkSlice("rst.s1", 8'hC3, 8'hB2);
    tick(); checkSlice("rst.s2", 8'hB2, 8'hC3);
    reset = 1'b1;
    applyStimulus(32'h11223344);
    checkPop("rst.popGated", 1'b0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst.state", 32'({outValid1, outValid0, busy1, busy0}), 32'h0);
    checkOutput("rst.data", 32'({outData1, outData0}), 32'h0);
    checkPop("rst.repop", 1'b1);
    tick();
    tick(); checkSlice("rst.n0", 8'h44, 8'h11);
    tick(); checkSlice("rst.n1", 8'h33, 8'h22);
    tick(); checkSlice("rst.n2", 8'h22, 8'h33);
    tick(); checkSlice("rst.n3", 8'h11, 8'h44);
    tick(); checkIdle("rst.done");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
